// File: rtl/id.sv
// RV64I decode stage: turns one fetched instruction into registered EX operands.
// Supports ADD/SUB/XOR/OR/AND, their immediate forms, LUI and AUIPC, with forwarding from EX.
package riscv_alu_pkg;
    localparam logic [3:0] RISCV_ALU_ADD = 4'd1;
    localparam logic [3:0] RISCV_ALU_SUB = 4'd2;
    localparam logic [3:0] RISCV_ALU_XOR = 4'd3;
    localparam logic [3:0] RISCV_ALU_OR  = 4'd4;
    localparam logic [3:0] RISCV_ALU_AND = 4'd5;
endpackage

module id
    import riscv_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_i,
    input  logic [63:0] pc_i,
    output logic        inst_ready_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [63:0] rs1_data_i,
    input  logic [63:0] rs2_data_i,
    input  logic [63:0] ex_result_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [63:0] oprand1,
    output logic [63:0] oprand2,
    output logic [7:0]  aluop,
    output logic [3:0]  alusel,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output logic        ex_valid_o,
    output logic        illegal_o,
    output logic [15:0] illegal_cnt_o
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [63:0] oprand1_q, oprand1_d, oprand2_q, oprand2_d;
    logic [7:0]  aluop_q, aluop_d;
    logic [3:0]  alusel_q, alusel_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        rd_we_q, rd_we_d, ex_valid_q, ex_valid_d, illegal_q, illegal_d;
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    logic        hold, accept, fwd_ok;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [63:0] src1, src2, imm_i, imm_u;
    logic        dec_legal;
    logic [3:0]  dec_alusel;
    logic [63:0] dec_op1, dec_op2;
    logic [7:0]  dec_aluop;

    assign hold         = stall_i && ex_valid_q;
    assign inst_ready_o = !hold;
    assign accept       = inst_valid_i && inst_ready_o;
    assign rs1_addr_o   = inst_i[19:15];
    assign rs2_addr_o   = inst_i[24:20];

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign imm_i  = {{52{inst_i[31]}}, inst_i[31:20]};
    assign imm_u  = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};

    // A flushed EX op never produces a result worth forwarding.
    assign fwd_ok = ex_valid_q && rd_we_q && !flush_i;

    always_comb begin
        src1 = rs1_data_i;
        src2 = rs2_data_i;
        if (rs1_addr_o == 5'd0)                          src1 = '0;
        else if (fwd_ok && rs1_addr_o == rd_addr_q)      src1 = ex_result_i;
        if (rs2_addr_o == 5'd0)                          src2 = '0;
        else if (fwd_ok && rs2_addr_o == rd_addr_q)      src2 = ex_result_i;
    end

    always_comb begin
        dec_legal  = 1'b0;
        dec_alusel = RISCV_ALU_ADD;
        dec_op1    = '0;
        dec_op2    = '0;
        case (opcode)
            OPC_OP: begin
                dec_op1 = src1;
                dec_op2 = src2;
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'b000: begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_ADD; end
                        3'b100: begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_XOR; end
                        3'b110: begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_OR;  end
                        3'b111: begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_AND; end
                        default: ;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                    dec_legal  = 1'b1;
                    dec_alusel = RISCV_ALU_SUB;
                end
            end
            OPC_OP_IMM: begin
                dec_op1 = src1;
                dec_op2 = imm_i;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_ADD; end
                    3'b100: begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_XOR; end
                    3'b110: begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_OR;  end
                    3'b111: begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_AND; end
                    default: ;
                endcase
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_op2   = imm_u;
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_op1   = pc_i;
                dec_op2   = imm_u;
            end
            default: ;
        endcase
        // Illegal encodings issue as a harmless ADD 0,0 that writes nothing.
        if (!dec_legal) begin
            dec_alusel = RISCV_ALU_ADD;
            dec_op1    = '0;
            dec_op2    = '0;
        end
    end

    assign dec_aluop = {inst_i[6:2], (opcode == OPC_LUI || opcode == OPC_AUIPC) ? 3'b000 : funct3};

    always_comb begin
        oprand1_d     = oprand1_q;
        oprand2_d     = oprand2_q;
        aluop_d       = aluop_q;
        alusel_d      = alusel_q;
        rd_addr_d     = rd_addr_q;
        rd_we_d       = rd_we_q;
        ex_valid_d    = ex_valid_q;
        illegal_d     = illegal_q;
        illegal_cnt_d = illegal_cnt_q;
        if (flush_i || (!hold && !accept)) begin
            ex_valid_d = 1'b0;
            rd_we_d    = 1'b0;
            illegal_d  = 1'b0;
        end else if (accept) begin
            oprand1_d  = dec_op1;
            oprand2_d  = dec_op2;
            aluop_d    = dec_aluop;
            alusel_d   = dec_alusel;
            rd_addr_d  = inst_i[11:7];
            rd_we_d    = dec_legal && (inst_i[11:7] != 5'd0);
            ex_valid_d = 1'b1;
            illegal_d  = !dec_legal;
            if (!dec_legal && illegal_cnt_q != 16'hFFFF)
                illegal_cnt_d = illegal_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oprand1_q     <= '0;
            oprand2_q     <= '0;
            aluop_q       <= '0;
            alusel_q      <= '0;
            rd_addr_q     <= '0;
            rd_we_q       <= 1'b0;
            ex_valid_q    <= 1'b0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            oprand1_q     <= oprand1_d;
            oprand2_q     <= oprand2_d;
            aluop_q       <= aluop_d;
            alusel_q      <= alusel_d;
            rd_addr_q     <= rd_addr_d;
            rd_we_q       <= rd_we_d;
            ex_valid_q    <= ex_valid_d;
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign oprand1       = oprand1_q;
    assign oprand2       = oprand2_q;
    assign aluop         = aluop_q;
    assign alusel        = alusel_q;
    assign rd_addr_o     = rd_addr_q;
    assign rd_we_o       = rd_we_q;
    assign ex_valid_o    = ex_valid_q;
    assign illegal_o     = illegal_q;
    assign illegal_cnt_o = illegal_cnt_q;
endmodule

// File: tb/tb_id.sv
// Bench for the decode stage: a reference model predicts the ID/EX register each cycle,
// directed cases pin the documented examples, then a random mix runs through the scoreboard.
module tb_id;
    import riscv_alu_pkg::*;

    typedef struct packed {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [7:0]  aluop;
        logic [3:0]  alusel;
        logic [4:0]  rd;
        logic        rd_we;
        logic        ex_valid;
        logic        illegal;
        logic [15:0] cnt;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i;
    logic [31:0] inst_i;
    logic [63:0] pc_i;
    logic        inst_ready_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    logic [63:0] rs1_data_i, rs2_data_i, ex_result_i;
    logic        stall_i, flush_i;
    logic [63:0] oprand1, oprand2;
    logic [7:0]  aluop;
    logic [3:0]  alusel;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o, ex_valid_o, illegal_o;
    logic [15:0] illegal_cnt_o;

    always #5 clk = ~clk;

    id dut (
        .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_i(inst_i), .pc_i(pc_i),
        .inst_ready_o(inst_ready_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .ex_result_i(ex_result_i),
        .stall_i(stall_i), .flush_i(flush_i), .oprand1(oprand1), .oprand2(oprand2),
        .aluop(aluop), .alusel(alusel), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o),
        .ex_valid_o(ex_valid_o), .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
    );

    int n_assert = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    exp_t model = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t ref_decode(input exp_t cur, input logic [31:0] ins, input logic [63:0] pc,
                                        input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] exr);
        exp_t n;
        logic [63:0] a, b, immi, immu;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic ok;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        immi = {{52{ins[31]}}, ins[31:20]};
        immu = {{32{ins[31]}}, ins[31:12], 12'h000};
        a = (ins[19:15] == 5'd0) ? 64'd0 :
            (cur.ex_valid && cur.rd_we && cur.rd == ins[19:15]) ? exr : d1;
        b = (ins[24:20] == 5'd0) ? 64'd0 :
            (cur.ex_valid && cur.rd_we && cur.rd == ins[24:20]) ? exr : d2;
        n = cur;
        ok = 1'b0;
        n.alusel = RISCV_ALU_ADD;
        n.op1 = 64'd0;
        n.op2 = 64'd0;
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) begin ok = 1; n.op1 = a; n.op2 = b; end
        if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin ok = 1; n.op1 = a; n.op2 = b; n.alusel = RISCV_ALU_SUB; end
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd4) begin ok = 1; n.op1 = a; n.op2 = b; n.alusel = RISCV_ALU_XOR; end
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6) begin ok = 1; n.op1 = a; n.op2 = b; n.alusel = RISCV_ALU_OR; end
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) begin ok = 1; n.op1 = a; n.op2 = b; n.alusel = RISCV_ALU_AND; end
        if (op == 7'h13 && f3 == 3'd0) begin ok = 1; n.op1 = a; n.op2 = immi; end
        if (op == 7'h13 && f3 == 3'd4) begin ok = 1; n.op1 = a; n.op2 = immi; n.alusel = RISCV_ALU_XOR; end
        if (op == 7'h13 && f3 == 3'd6) begin ok = 1; n.op1 = a; n.op2 = immi; n.alusel = RISCV_ALU_OR; end
        if (op == 7'h13 && f3 == 3'd7) begin ok = 1; n.op1 = a; n.op2 = immi; n.alusel = RISCV_ALU_AND; end
        if (op == 7'h37) begin ok = 1; n.op2 = immu; end
        if (op == 7'h17) begin ok = 1; n.op1 = pc; n.op2 = immu; end
        n.aluop = {ins[6:2], (op == 7'h37 || op == 7'h17) ? 3'd0 : f3};
        n.rd = ins[11:7];
        n.rd_we = ok && (ins[11:7] != 5'd0);
        n.ex_valid = 1'b1;
        n.illegal = !ok;
        if (!ok && cur.cnt != 16'hFFFF) n.cnt = cur.cnt + 16'd1;
        return n;
    endfunction

    function automatic exp_t model_next(input exp_t cur, input logic v, input logic [31:0] ins, input logic [63:0] pc,
                                        input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] exr,
                                        input logic st, input logic fl, input logic rs);
        exp_t n;
        n = cur;
        if (rs) n = '0;
        else if (fl || (!(st && cur.ex_valid) && !v)) begin
            n.ex_valid = 1'b0; n.rd_we = 1'b0; n.illegal = 1'b0;
        end else if (!(st && cur.ex_valid)) n = ref_decode(cur, ins, pc, d1, d2, exr);
        return n;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] exr,
                        input logic st, input logic fl, input logic rs);
        exp_t e;
        inst_valid_i = v; inst_i = ins; pc_i = pc; rs1_data_i = d1; rs2_data_i = d2;
        ex_result_i = exr; stall_i = st; flush_i = fl; rst = rs;
        #1;
        check("inst_ready", 64'(inst_ready_o), 64'(!(st && model.ex_valid)));
        check("rs1_addr", 64'(rs1_addr_o), 64'(ins[19:15]));
        check("rs2_addr", 64'(rs2_addr_o), 64'(ins[24:20]));
        model = model_next(model, v, ins, pc, d1, d2, exr, st, fl, rs);
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("oprand1", oprand1, e.op1);
        check("oprand2", oprand2, e.op2);
        if (!e.illegal) check("aluop", 64'(aluop), 64'(e.aluop));
        check("alusel", 64'(alusel), 64'(e.alusel));
        check("rd_addr", 64'(rd_addr_o), 64'(e.rd));
        check("rd_we", 64'(rd_we_o), 64'(e.rd_we));
        check("ex_valid", 64'(ex_valid_o), 64'(e.ex_valid));
        check("illegal", 64'(illegal_o), 64'(e.illegal));
        check("illegal_cnt", 64'(illegal_cnt_o), 64'(e.cnt));
    endtask

    function automatic logic [31:0] gen_inst();
        logic [4:0] rd, r1, r2;
        logic [11:0] imm;
        logic [2:0] f3sel;
        rd = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        imm = 12'($urandom());
        f3sel = ($urandom_range(0, 2) == 0) ? 3'd4 : (($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7);
        case ($urandom_range(0, 9))
            0: return {7'h00, r2, r1, 3'd0, rd, 7'h33};
            1: return {7'h20, r2, r1, 3'd0, rd, 7'h33};
            2: return {7'h00, r2, r1, f3sel, rd, 7'h33};
            3: return {imm, r1, 3'd0, rd, 7'h13};
            4: return {imm, r1, f3sel, rd, 7'h13};
            5: return {20'($urandom()), rd, 7'h37};
            6: return {20'($urandom()), rd, 7'h17};
            7: return 32'($urandom());
            8: return {7'h00, r2, r1, 3'd1, rd, 7'h33};
            default: return {imm, r1, 3'd2, rd, 7'h13};
        endcase
    endfunction

    initial begin
        logic [63:0] snap_op1;
        logic [31:0] ins;
        step(0, 32'h0, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 1);
        step(0, 32'h0, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 1);
        check("reset_alusel", 64'(alusel), 64'd0);
        check("reset_ready", 64'(inst_ready_o), 64'd1);

        step(1, 32'h00500093, 64'h100, 64'hDEAD, 64'hBEEF, 64'h0, 0, 0, 0);
        check("addi_op1", oprand1, 64'd0);
        check("addi_op2", oprand2, 64'd5);
        check("addi_alusel", 64'(alusel), 64'(RISCV_ALU_ADD));
        check("addi_rd", 64'(rd_addr_o), 64'd1);
        check("addi_we", 64'(rd_we_o & ex_valid_o), 64'd1);

        step(1, 32'h402081B3, 64'h104, 64'h777, 64'd3, 64'h10, 0, 0, 0);
        check("sub_fwd_op1", oprand1, 64'h10);
        check("sub_op2", oprand2, 64'd3);
        check("sub_alusel", 64'(alusel), 64'(RISCV_ALU_SUB));

        step(1, 32'h123452B7, 64'h108, 64'h1, 64'h2, 64'h0, 0, 0, 0);
        check("lui_op1", oprand1, 64'd0);
        check("lui_op2", oprand2, 64'h0000000012345000);
        step(1, 32'h800002B7, 64'h10C, 64'h1, 64'h2, 64'h0, 0, 0, 0);
        check("lui_neg_op2", oprand2, 64'hFFFFFFFF80000000);

        step(1, 32'h00001317, 64'h1000, 64'h1, 64'h2, 64'h0, 0, 0, 0);
        check("auipc_op1", oprand1, 64'h1000);
        check("auipc_op2", oprand2, 64'h1000);
        check("auipc_aluop", 64'(aluop), 64'h28);

        step(1, 32'h0020C3B3, 64'h1004, 64'h55, 64'h66, 64'h0, 0, 0, 0);
        snap_op1 = 64'h55;
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h0020E433, 64'h1008, 64'h99, 64'hAA, 64'h0, 1, 0, 0);
            check("stall_ready", 64'(inst_ready_o), 64'd0);
            check("stall_frozen_op1", oprand1, snap_op1);
            check("stall_frozen_sel", 64'(alusel), 64'(RISCV_ALU_XOR));
        end
        step(1, 32'h0020E433, 64'h1008, 64'h99, 64'hAA, 64'h0, 0, 0, 0);
        check("release_sel", 64'(alusel), 64'(RISCV_ALU_OR));
        check("release_rd", 64'(rd_addr_o), 64'd8);

        step(1, 32'h0, 64'h2000, 64'h1, 64'h2, 64'h0, 0, 0, 0);
        step(1, 32'h0, 64'h2004, 64'h1, 64'h2, 64'h0, 0, 0, 0);
        check("illegal_flag", 64'(illegal_o), 64'd1);
        check("illegal_we", 64'(rd_we_o), 64'd0);
        check("illegal_cnt2", 64'(illegal_cnt_o), 64'd2);
        step(1, 32'h0, 64'h2008, 64'h1, 64'h2, 64'h0, 0, 1, 0);
        check("flush_cnt", 64'(illegal_cnt_o), 64'd2);
        check("flush_valid", 64'(ex_valid_o), 64'd0);

        for (int i = 0; i < 300; i++) begin
            ins = gen_inst();
            step(($urandom_range(0, 3) != 0), ins, {$urandom(), $urandom()},
                 {$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
        end

        step(1, 32'h0020C3B3, 64'h3000, 64'h5, 64'h6, 64'h0, 0, 0, 0);
        step(1, 32'h0020E433, 64'h3004, 64'h5, 64'h6, 64'h0, 1, 0, 0);
        step(1, 32'h0020E433, 64'h3004, 64'h5, 64'h6, 64'h0, 1, 0, 1);
        check("rst_stall_op1", oprand1, 64'd0);
        check("rst_stall_valid", 64'(ex_valid_o), 64'd0);
        check("rst_stall_cnt", 64'(illegal_cnt_o), 64'd0);
        check("rst_stall_ready", 64'(inst_ready_o), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
